// File: rtl/nes_joypad_pkg.sv
// nes_joypad_pkg
//   Shared constants and types for the NES joypad emulation:
//   HID keycodes consumed by the decoder, NES button bit positions,
//   and the 8-bit button vector type.
package nes_joypad_pkg;

  localparam logic [7:0] KEY_K     = 8'h0E;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_I     = 8'h0C;
  localparam logic [7:0] KEY_U     = 8'h18;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] btn_vec_t;

endpackage

// File: rtl/nes_key_decode.sv
// nes_key_decode
//   Purely combinational map from one HID keycode to the NES button vector.
//   At most one button bit is ever set.
//   Build option: NES_JOYPAD_TURBO_EN adds turbo A (I) and turbo B (U),
//   which follow turbo_phase instead of being held solid.
// Ports:
//   keycode      in   HID keycode, 0x00 = no key
//   turbo_phase  in   turbo square wave (only with NES_JOYPAD_TURBO_EN)
//   btn          out  decoded button vector
module nes_key_decode
  import nes_joypad_pkg::*;
(
  input  logic [7:0] keycode,
`ifdef NES_JOYPAD_TURBO_EN
  input  logic       turbo_phase,
`endif
  output btn_vec_t   btn
);

  always_comb begin
    btn = '0;
    case (keycode)
      KEY_K:     btn[BTN_A]      = 1'b1;
      KEY_J:     btn[BTN_B]      = 1'b1;
      KEY_SPACE: btn[BTN_SELECT] = 1'b1;
      KEY_ENTER: btn[BTN_START]  = 1'b1;
      KEY_W:     btn[BTN_UP]     = 1'b1;
      KEY_S:     btn[BTN_DOWN]   = 1'b1;
      KEY_A:     btn[BTN_LEFT]   = 1'b1;
      KEY_D:     btn[BTN_RIGHT]  = 1'b1;
`ifdef NES_JOYPAD_TURBO_EN
      KEY_I:     btn[BTN_A]      = turbo_phase;
      KEY_U:     btn[BTN_B]      = turbo_phase;
`endif
      default:   btn = '0;
    endcase
  end

endmodule

// File: rtl/nes_joypad.sv
// nes_joypad
//   NES standard controller at $4016: keycode -> button register, strobe
//   latch, and serial shift-on-read. After eight reads the shifter has
//   filled with ones from the MSB, so every further read returns 1.
//   Build option: NES_JOYPAD_TURBO_EN adds a free-running turbo counter
//   (TURBO_DIV clk cycles per half-period) feeding the turbo keys.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   keycode    in   HID keycode from the keycode PIO
//   strobe_we  in   one-cycle pulse, CPU write to $4016
//   strobe_d   in   write data bit 0
//   rd_en      in   one-cycle pulse, CPU read of $4016
//   rd_data    out  current serial bit (D0)
//   buttons    out  registered button vector
module nes_joypad
  import nes_joypad_pkg::*;
#(
  parameter int unsigned TURBO_DIV = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       strobe_we,
  input  logic       strobe_d,
  input  logic       rd_en,
  output logic       rd_data,
  output logic [7:0] buttons
);

  btn_vec_t btn_q, btn_d;
  btn_vec_t shreg_q, shreg_d;
  // strobe_d is taken by the CPU data port, so the next-state uses _nxt
  logic     strobe_q, strobe_nxt;
  btn_vec_t dec_btn;

`ifdef NES_JOYPAD_TURBO_EN
  localparam int unsigned TURBO_LAST = TURBO_DIV - 1;

  logic [31:0] turbo_cnt_q, turbo_cnt_d;
  logic        turbo_phase_q, turbo_phase_d;

  always_comb begin
    turbo_cnt_d   = turbo_cnt_q + 32'd1;
    turbo_phase_d = turbo_phase_q;
    if (turbo_cnt_q == TURBO_LAST) begin
      turbo_cnt_d   = '0;
      turbo_phase_d = ~turbo_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
    end
  end

  nes_key_decode u_decode (
    .keycode     (keycode),
    .turbo_phase (turbo_phase_q),
    .btn         (dec_btn)
  );
`else
  logic turbo_unused;
  assign turbo_unused = (TURBO_DIV == 0);

  nes_key_decode u_decode (
    .keycode (keycode),
    .btn     (dec_btn)
  );
`endif

  always_comb begin
    btn_d      = dec_btn;
    strobe_nxt = strobe_we ? strobe_d : strobe_q;
    shreg_d    = shreg_q;
    // Reload uses the pre-write strobe, so the 1->0 write cycle still
    // latches and a read in that same cycle does not shift.
    if (strobe_q) begin
      shreg_d = btn_q;
    end else if (rd_en) begin
      shreg_d = {1'b1, shreg_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_q    <= '0;
      strobe_q <= 1'b0;
      shreg_q  <= '0;
    end else begin
      btn_q    <= btn_d;
      strobe_q <= strobe_nxt;
      shreg_q  <= shreg_d;
    end
  end

  assign rd_data = strobe_q ? btn_q[0] : shreg_q[0];
  assign buttons = btn_q;

endmodule

// File: tb/tb_nes_joypad.sv
module tb_nes_joypad;

  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       strobe_we = 1'b0;
  logic       strobe_d = 1'b0;
  logic       rd_en = 1'b0;
  logic       rd_data;
  logic [7:0] buttons;

  always #5 clk = ~clk;

  nes_joypad #(.TURBO_DIV(TDIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode   (keycode),
    .strobe_we (strobe_we),
    .strobe_d  (strobe_d),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .buttons   (buttons)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: button table, a latched byte and a read index.
  logic [7:0] keymap [256];
  logic       m_valid = 1'b0;
  logic [7:0] m_btn = 8'h00;
  logic [7:0] m_latch = 8'h00;
  logic       m_strobe = 1'b0;
  int         m_idx = 0;
  int         m_cyc = 0;

  function automatic logic m_rd();
    if (m_strobe) return m_btn[0];
    if (m_idx < 8) return m_latch[m_idx];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_btn = 8'h00; m_latch = 8'h00; m_strobe = 1'b0;
      m_idx = 0; m_cyc = 0; m_valid = 1'b1;
    end else begin
      if (m_strobe) begin
        m_latch = m_btn;
        m_idx = 0;
      end else if (rd_en && m_idx < 8) begin
        m_idx++;
      end
      if (strobe_we) m_strobe = strobe_d;
      m_btn = keymap[keycode];
`ifdef NES_JOYPAD_TURBO_EN
      if (keycode == 8'h0C) m_btn = {7'b0, 1'(((m_cyc / TDIV) % 2))};
      if (keycode == 8'h18) m_btn = {6'b0, 1'(((m_cyc / TDIV) % 2)), 1'b0};
`endif
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_buttons", buttons, m_btn);
      chk("model_rd_data", {7'b0, rd_data}, {7'b0, m_rd()});
    end
  end

  // Stimulus: nxt_* are applied together with the step's strobe/read.
  logic [7:0] nxt_kc = 8'h00;
  logic       nxt_rst = 1'b0;
  logic       rb;

  task automatic step(input logic we, input logic d, input logic rd, output logic rbit);
    @(negedge clk);
    reset_n = nxt_rst; keycode = nxt_kc;
    strobe_we = we; strobe_d = d; rd_en = rd;
    #1 rbit = rd_data;
  endtask

  task automatic idle();
    logic dummy;
    step(1'b0, 1'b0, 1'b0, dummy);
  endtask

  task automatic rd(output logic rbit);
    step(1'b0, 1'b0, 1'b1, rbit);
    idle();
  endtask

  task automatic latch();
    logic dummy;
    step(1'b1, 1'b1, 1'b0, dummy);
    step(1'b1, 1'b0, 1'b0, dummy);
  endtask

  logic [7:0] pat;
  logic [7:0] codes [12];
  logic       s [40];
  int         first;

  initial begin
    for (int i = 0; i < 256; i++) keymap[i] = 8'h00;
    keymap[8'h0E] = 8'h01; keymap[8'h0D] = 8'h02;
    keymap[8'h2C] = 8'h04; keymap[8'h28] = 8'h08;
    keymap[8'h1A] = 8'h10; keymap[8'h16] = 8'h20;
    keymap[8'h04] = 8'h40; keymap[8'h07] = 8'h80;
    codes = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07,
              8'h0C, 8'h18, 8'h00, 8'h05};

    // 1: reset, then ten reads of an empty shifter
    nxt_rst = 1'b0;
    repeat (3) idle();
    nxt_rst = 1'b1;
    idle();
    chk("reset_buttons", buttons, 8'h00);
    chk("reset_rd_data", {7'b0, rd_data}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      rd(rb);
      chk("reset_read", {7'b0, rb}, (i >= 8) ? 8'h01 : 8'h00);
    end

    // 2: A held, latched, read out
    nxt_kc = 8'h0E;
    idle();
    idle();
    chk("a_buttons_latency", buttons, 8'h01);
    latch();
    pat = 8'h01;
    for (int i = 0; i < 8; i++) begin
      rd(rb);
      chk("a_read", {7'b0, rb}, {7'b0, pat[i]});
    end

    // 3: Right latched, then released before reading
    nxt_kc = 8'h07;
    idle();
    latch();
    nxt_kc = 8'h00;
    idle();
    pat = 8'h80;
    for (int i = 0; i < 8; i++) begin
      rd(rb);
      chk("right_read", {7'b0, rb}, {7'b0, pat[i]});
    end

    // 4: reads while strobe high do not shift
    nxt_kc = 8'h0D;
    idle();
    step(1'b1, 1'b1, 1'b0, rb);
    for (int i = 0; i < 3; i++) begin
      rd(rb);
      chk("strobe_high_read", {7'b0, rb}, 8'h00);
    end
    step(1'b1, 1'b0, 1'b0, rb);
    rd(rb); chk("b_read0", {7'b0, rb}, 8'h00);
    rd(rb); chk("b_read1", {7'b0, rb}, 8'h01);

    // 5: read coincident with the 1->0 strobe write
    nxt_kc = 8'h0E;
    idle();
    step(1'b1, 1'b1, 1'b0, rb);
    idle();
    step(1'b1, 1'b0, 1'b1, rb);
    chk("coinc_read", {7'b0, rb}, 8'h01);
    idle();
    rd(rb); chk("coinc_next0", {7'b0, rb}, 8'h01);
    rd(rb); chk("coinc_next1", {7'b0, rb}, 8'h00);

    // reset mid-sequence discards latched data
    nxt_kc = 8'h0E;
    latch();
    rd(rb); chk("pre_reset_read", {7'b0, rb}, 8'h01);
    nxt_rst = 1'b0;
    idle();
    nxt_rst = 1'b1;
    nxt_kc = 8'h00;
    idle();
    rd(rb); chk("post_reset_read", {7'b0, rb}, 8'h00);

    // 6: turbo key
    nxt_kc = 8'h0C;
    idle();
    for (int i = 0; i < 40; i++) begin
      idle();
      s[i] = buttons[0];
    end
`ifdef NES_JOYPAD_TURBO_EN
    first = 0;
    for (int i = 1; i < 6; i++) if (first == 0 && s[i] != s[i-1]) first = i;
    chk("turbo_edge_found", {7'b0, (first != 0)}, 8'h01);
    for (int j = 0; j < 24; j++)
      chk("turbo_period", {7'b0, s[first + j]}, {7'b0, s[first] ^ 1'(((j / 4) % 2))});
`else
    first = 0;
    for (int i = 0; i < 40; i++) if (s[i]) first++;
    chk("no_turbo_i", first[7:0], 8'h00);
    nxt_kc = 8'h18;
    idle(); idle();
    chk("no_turbo_u", buttons, 8'h00);
`endif

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      logic we, d, r;
      if ($urandom_range(7) == 0) nxt_kc = codes[$urandom_range(11)];
      if ($urandom_range(31) == 0) nxt_kc = 8'($urandom);
      nxt_rst = ($urandom_range(199) != 0);
      we = ($urandom_range(5) == 0);
      d  = 1'($urandom_range(1));
      r  = ($urandom_range(2) == 0);
      step(we, d, r, rb);
    end
    nxt_rst = 1'b1;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
